// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO behind a valid/ready input
module uart_tx #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          TXD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift_reg, shift_d;
    logic          txd_d, push, pop, bit_end, has_data;

    assign in_ready   = level != LW'(FIFO_DEPTH);
    assign fifo_level = level;
    assign busy       = (state != IDLE) || has_data;
    assign has_data   = level != '0;
    assign push       = in_valid && in_ready;
    assign bit_end    = cnt == CNT_MAX;

    always_comb begin
        state_d = state;
        cnt_d   = bit_end ? '0 : cnt + 1'b1;
        idx_d   = idx;
        shift_d = shift_reg;
        txd_d   = TXD;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (has_data) begin
                    pop     = 1'b1;
                    state_d = START;
                    txd_d   = 1'b0;
                    shift_d = mem[rd_ptr];
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                idx_d   = '0;
                txd_d   = shift_reg[0];
            end
            DATA: if (bit_end) begin
                if (idx == 3'd7) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end else begin
                    idx_d = idx + 3'd1;
                    txd_d = shift_reg[idx + 3'd1];
                end
            end
            STOP: if (bit_end) begin
                // chain straight into the next start bit so queued frames are contiguous
                if (has_data) begin
                    pop     = 1'b1;
                    state_d = START;
                    txd_d   = 1'b0;
                    shift_d = mem[rd_ptr];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift_reg <= '0;
            TXD       <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            shift_reg <= shift_d;
            TXD       <= txd_d;
            wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level     <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a frame-decoding scoreboard monitor on TXD
module tb_uart_tx;
    localparam int CPB = 4;
    localparam int FB  = 10 * CPB;

    typedef struct {
        logic [7:0] data;
        bit         contig;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, TXD, busy;
    logic [2:0] fifo_level;

    int compared = 0;
    int mismatched = 0;
    exp_t exp_q[$];

    int          mcyc = 0, mk = 0, mst = 0, mlast = 0;
    bit          minf = 1'b0;
    logic [FB-1:0] ms;
    exp_t        me;
    int          n;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .TXD(TXD), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int c);
        repeat (c) @(posedge CLK);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit contig);
        exp_t e;
        e.data = d;
        e.contig = contig;
        exp_q.push_back(e);
    endtask

    function automatic logic [FB-1:0] wave(input logic [7:0] d);
        logic [FB-1:0] w;
        for (int k = 0; k < FB; k++) begin
            if (k / CPB == 0) w[k] = 1'b0;
            else if (k / CPB == 9) w[k] = 1'b1;
            else w[k] = d[k / CPB - 1];
        end
        return w;
    endfunction

    // Receiver model: a frame begins at the first low sample and spans FB samples
    initial begin
        forever begin
            @(negedge CLK);
            mcyc++;
            if (!RESET) begin
                minf = 1'b0;
            end else begin
                if (!minf && TXD === 1'b0) begin
                    minf = 1'b1;
                    mk = 0;
                    mst = mcyc;
                end
                if (minf) begin
                    ms[mk] = TXD;
                    mk++;
                    if (mk == FB) begin
                        minf = 1'b0;
                        chk("frame_was_expected", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            me = exp_q.pop_front();
                            chk("frame_wave", 64'(ms), 64'(wave(me.data)));
                            if (me.contig) chk("frame_gap", 64'(mst - mlast), 64'(FB));
                        end
                        mlast = mst;
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v3 [5] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F};
        logic [7:0] v4 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] v6 [3] = '{8'hC3, 8'h5A, 8'h7E};

        tick(3);
        RESET = 1'b1;
        chk("rst_txd", 64'(TXD), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        tick(10);
        chk("idle_txd", 64'(TXD), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        in_data = 8'hA5;
        in_valid = 1'b1;
        expect_frame(8'hA5, 1'b0);
        tick(1);
        in_valid = 1'b0;
        chk("single_level_e", 64'(fifo_level), 64'd1);
        chk("single_busy_e", 64'(busy), 64'd1);
        chk("single_txd_e", 64'(TXD), 64'd1);
        tick(1);
        chk("single_txd_start", 64'(TXD), 64'd0);
        chk("single_level_pop", 64'(fifo_level), 64'd0);
        tick(39);
        chk("single_busy_e40", 64'(busy), 64'd1);
        chk("single_stop_txd", 64'(TXD), 64'd1);
        tick(1);
        chk("single_busy_e41", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++) begin
            in_data = v3[i];
            in_valid = 1'b1;
            expect_frame(v3[i], i != 0);
            tick(1);
        end
        chk("b2b_level_full", 64'(fifo_level), 64'd4);
        chk("b2b_in_ready_full", 64'(in_ready), 64'd0);
        in_data = 8'h33;
        tick(1);
        in_valid = 1'b0;
        chk("b2b_refused_level", 64'(fifo_level), 64'd4);
        n = 0;
        while (busy && n < 400) begin
            tick(1);
            n++;
        end
        chk("b2b_duration", 64'(n), 64'd196);

        for (int i = 0; i < 5; i++) begin
            in_data = v4[i];
            in_valid = 1'b1;
            expect_frame(v4[i], i != 0);
            tick(1);
        end
        in_valid = 1'b0;
        tick(36);
        chk("fullpop_level_before", 64'(fifo_level), 64'd4);
        chk("fullpop_ready_before", 64'(in_ready), 64'd0);
        in_data = 8'h66;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("fullpop_level_after", 64'(fifo_level), 64'd3);
        chk("fullpop_ready_after", 64'(in_ready), 64'd1);
        tick(119);
        chk("pushpop_level_before", 64'(fifo_level), 64'd1);
        in_data = 8'h3C;
        in_valid = 1'b1;
        expect_frame(8'h3C, 1'b1);
        tick(1);
        in_valid = 1'b0;
        chk("pushpop_level_after", 64'(fifo_level), 64'd1);
        chk("pushpop_txd_start", 64'(TXD), 64'd0);
        n = 0;
        while (busy && n < 400) begin
            tick(1);
            n++;
        end
        chk("pushpop_drain", 64'(n), 64'd80);

        for (int i = 0; i < 3; i++) begin
            in_data = v6[i];
            in_valid = 1'b1;
            expect_frame(v6[i], i != 0);
            tick(1);
        end
        in_valid = 1'b0;
        tick(16);
        chk("midrst_txd_bit3", 64'(TXD), 64'd0);
        chk("midrst_level_before", 64'(fifo_level), 64'd2);
        RESET = 1'b0;
        exp_q.delete();
        tick(1);
        chk("midrst_txd", 64'(TXD), 64'd1);
        chk("midrst_level", 64'(fifo_level), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        RESET = 1'b1;
        tick(100);
        chk("post_rst_txd", 64'(TXD), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_level", 64'(fifo_level), 64'd0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter that drives the board TXD pin, which is currently tied low.
- Accepts bytes from an on-chip producer through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte at a baud rate derived from CLK by an internal bit-period counter.
- First consumer: the LED counter path, which streams its count value to the host.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 104 by default), clocks per bit period. Overridable; must be >= 2.
- FIFO_DEPTH, 4, byte FIFO entries. Power of two, >= 2.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset (0 = reset, sampled on the CLK rising edge).
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a byte.
- TXD  out  1  serial line; idles high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset values (any edge with RESET=0): TXD=1, in_ready=1, busy=0, fifo_level=0.
  - FIFO pointers cleared; state IDLE; bit counter and bit index cleared.
- Reset mid-frame: the frame is aborted and TXD=1 after that edge. FIFO contents are discarded.
- Handshake:
  - in_ready = (fifo_level != FIFO_DEPTH), driven only from registers.
  - A byte is accepted on an edge where in_valid && in_ready.
  - in_valid with in_ready=0 is ignored; the producer holds its data.
- Full FIFO plus pop on the same edge: the write is NOT accepted (in_ready was 0). No pass-through.
- Level arithmetic: on the same edge, push and pop both apply.
  - Push only: +1. Pop only: -1. Push and pop: unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - TXD=1.
  - If fifo_level != 0 on an edge: pop the head into shift_reg, clear the bit counter, go to START, TXD<=0.
- START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and TXD<=shift_reg[0].
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles, LSB first.
  - After bit 7, go to STOP with TXD<=1.
- STOP: TXD=1 for CLKS_PER_BIT cycles. At the end:
  - FIFO non-empty: pop and go directly to START. No extra idle cycle.
  - FIFO empty: go to IDLE.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Latency:
  - A byte accepted on edge E into an empty FIFO with the transmitter idle is popped on edge E+1.
  - TXD falls after edge E+1.
- busy = (state != IDLE) || (fifo_level != 0), registered-equivalent.
  - busy falls on the edge that enters IDLE with the FIFO empty.
- TXD is a registered output: no glitches, no combinational path from in_*.

Test Plan:
- Reset: RESET=0 for 3 cycles, then RESET=1 -> TXD=1, in_ready=1, busy=0, fifo_level=0, and TXD stays 1 with no input.
- Single byte, CLKS_PER_BIT=4: push 0xA5 at edge E.
  - Edge E+1: TXD=0 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then TXD=1 for 4 cycles.
  - busy drops at edge E+41.
- Back-to-back fill, CLKS_PER_BIT=4: push 0x00,0xFF,0x55,0xAA,0x0F on consecutive cycles.
  - The first is popped immediately and the next 4 fill the FIFO.
  - fifo_level reaches 4 and in_ready=0; a 6th push of 0x33 is refused.
  - Output is 5 contiguous frames (200 cycles) in order, with no idle gaps.
- Full + pop: with fifo_level=4, assert in_valid on the STOP-end edge -> byte not accepted, level goes to 3, in_ready=1 next cycle.
- Simultaneous push/pop: with fifo_level=1 at the STOP-end edge, push 0x3C -> fifo_level stays 1 and the next frame starts immediately.
- Reset mid-frame: assert RESET=0 during DATA bit 3 of 0xC3 with 2 bytes queued.
  - TXD=1 after that edge and fifo_level=0.
  - No further frames are sent after release.
